// File: rtl/scanout_engine.sv
// Pixel-clock scan-out engine: CRT timing, frame-buffer addressing with stride and
// pixel replication, 1..32 bpp unpacking, and a read-latency-matched output pipeline.
module scanout_engine #(
    parameter int CW     = 16,
    parameter int AW     = 15,
    parameter int RD_LAT = 1
) (
    input  logic          pxl_clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          enable,
    input  logic [CW-1:0] h_total,
    input  logic [CW-1:0] h_end_disp,
    input  logic [CW-1:0] h_srt_sync,
    input  logic [CW-1:0] h_end_sync,
    input  logic [CW-1:0] v_total,
    input  logic [CW-1:0] v_end_disp,
    input  logic [CW-1:0] v_srt_sync,
    input  logic [CW-1:0] v_end_sync,
    input  logic          hsync_pol,
    input  logic          vsync_pol,
    input  logic [AW-1:0] base_in,
    input  logic [AW-1:0] stride_in,
    input  logic [2:0]    depth_in,
    input  logic [1:0]    scale_in,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_data,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          vblank_irq,
    output logic [15:0]   frame_count
);

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [2:0] depth;
        logic [4:0] sub;
    } pix_t;

    // log2 of pixels per 32-bit word
    function automatic logic [2:0] word_shift(input logic [2:0] depth);
        case (depth)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            3'd3:    return 3'd3;
            3'd4:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [23:0] unpack(input logic [2:0] depth, input logic [4:0] sub,
                                           input logic [31:0] d);
        logic [15:0] hw;
        logic [7:0]  by;
        logic [3:0]  nb;
        logic        bt;
        hw = sub[0] ? d[31:16] : d[15:0];
        by = d[{sub[1:0], 3'b000} +: 8];
        nb = d[{sub[2:0], 2'b00} +: 4];
        bt = d[sub];
        case (depth)
            3'd1:    return {hw[15:11], hw[15:13], hw[10:5], hw[10:9], hw[4:0], hw[4:2]};
            3'd2:    return {by[7:5], by[7:5], by[7:6], by[4:2], by[4:2], by[4:3], {4{by[1:0]}}};
            3'd3:    return {6{nb}};
            3'd4:    return {24{bt}};
            default: return d[23:0];
        endcase
    endfunction

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [AW-1:0] base_sh_q, stride_sh_q, line_base_q, line_base_d;
    logic [2:0]    depth_sh_q;
    logic [1:0]    scale_sh_q;
    logic [15:0]   frame_q;
    logic          irq_q, irq_d;
    pix_t          pipe_q [RD_LAT];
    pix_t          pix_in;
    logic          de_q, hs_q, vs_q;
    logic [23:0]   rgb_q;

    logic          h_wrap, eof, act, step;
    logic [CW-1:0] px, v_mask;
    logic [AW-1:0] word_off;
    logic [2:0]    k;
    logic [4:0]    sub_mask;

    always_comb begin
        h_wrap   = (h_q == h_total - CW'(1));
        eof      = h_wrap && (v_q == v_total - CW'(1));
        act      = (h_q < h_end_disp) && (v_q < v_end_disp);
        // Lines repeat 2^scale times, so the source line advances after the last copy
        v_mask   = (CW'(1) << scale_sh_q) - CW'(1);
        step     = h_wrap && (v_q < v_end_disp) && ((v_q & v_mask) == v_mask);
        px       = h_q >> scale_sh_q;
        k        = word_shift(depth_sh_q);
        word_off = AW'(px >> k);
        sub_mask = 5'((6'd1 << k) - 6'd1);

        h_d = h_wrap ? '0 : h_q + CW'(1);
        v_d = v_q;
        if (h_wrap) v_d = eof ? '0 : v_q + CW'(1);

        line_base_d = line_base_q;
        if (eof)       line_base_d = base_in;
        else if (step) line_base_d = line_base_q + stride_sh_q;

        pix_in.act   = act;
        pix_in.hs    = (h_q >= h_srt_sync && h_q < h_end_sync) ? !hsync_pol : hsync_pol;
        pix_in.vs    = (v_q >= v_srt_sync && v_q < v_end_sync) ? !vsync_pol : vsync_pol;
        pix_in.depth = depth_sh_q;
        pix_in.sub   = px[4:0] & sub_mask;

        irq_d = clk_en && enable && h_wrap && (v_d == v_end_disp);
    end

    assign mem_en   = act & clk_en & enable & ~rst;
    assign mem_addr = (enable && !rst) ? line_base_q + word_off : '0;

    always_ff @(posedge pxl_clk or posedge rst) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            base_sh_q   <= '0;
            stride_sh_q <= '0;
            depth_sh_q  <= '0;
            scale_sh_q  <= '0;
            line_base_q <= '0;
            frame_q     <= '0;
        end else if (clk_en) begin
            if (!enable) begin
                h_q         <= '0;
                v_q         <= '0;
                base_sh_q   <= base_in;
                stride_sh_q <= stride_in;
                depth_sh_q  <= depth_in;
                scale_sh_q  <= scale_in;
                line_base_q <= base_in;
            end else begin
                h_q         <= h_d;
                v_q         <= v_d;
                line_base_q <= line_base_d;
                if (eof) begin
                    base_sh_q   <= base_in;
                    stride_sh_q <= stride_in;
                    depth_sh_q  <= depth_in;
                    scale_sh_q  <= scale_in;
                    frame_q     <= frame_q + 16'd1;
                end
            end
        end
    end

    // Read-latency stages: attributes travel beside the outstanding memory read
    always_ff @(posedge pxl_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
        end else if (clk_en) begin
            pipe_q[0] <= enable ? pix_in : '0;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= enable ? pipe_q[i-1] : '0;
            de_q  <= enable & pipe_q[RD_LAT-1].act;
            hs_q  <= enable & pipe_q[RD_LAT-1].hs;
            vs_q  <= enable & pipe_q[RD_LAT-1].vs;
            rgb_q <= (enable && pipe_q[RD_LAT-1].act) ?
                     unpack(pipe_q[RD_LAT-1].depth, pipe_q[RD_LAT-1].sub, mem_data) : '0;
        end
    end

    // Interrupt is a single pxl_clk pulse regardless of clk_en
    always_ff @(posedge pxl_clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign red         = enable ? rgb_q[23:16] : 8'd0;
    assign green       = enable ? rgb_q[15:8]  : 8'd0;
    assign blue        = enable ? rgb_q[7:0]   : 8'd0;
    assign hsync       = enable & hs_q;
    assign vsync       = enable & vs_q;
    assign de          = enable & de_q;
    assign vblank_irq  = enable & irq_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_scanout_engine.sv
// Scoreboard bench for scanout_engine: a reference timing/address/colour model pushes
// expected pixels when each enabled cycle is driven and pops them at the output.
module tb_scanout_engine;
    localparam int CW  = 16;
    localparam int AW  = 15;
    localparam int LAT = 3;

    logic          pxl_clk, rst, clk_en, enable;
    logic [CW-1:0] h_total, h_end_disp, h_srt_sync, h_end_sync;
    logic [CW-1:0] v_total, v_end_disp, v_srt_sync, v_end_sync;
    logic          hsync_pol, vsync_pol;
    logic [AW-1:0] base_in, stride_in;
    logic [2:0]    depth_in;
    logic [1:0]    scale_in;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [7:0]    red, green, blue;
    logic          hsync, vsync, de, vblank_irq;
    logic [15:0]   frame_count;

    scanout_engine #(.CW(CW), .AW(AW), .RD_LAT(LAT)) dut (
        .pxl_clk(pxl_clk), .rst(rst), .clk_en(clk_en), .enable(enable),
        .h_total(h_total), .h_end_disp(h_end_disp), .h_srt_sync(h_srt_sync), .h_end_sync(h_end_sync),
        .v_total(v_total), .v_end_disp(v_end_disp), .v_srt_sync(v_srt_sync), .v_end_sync(v_end_sync),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .base_in(base_in), .stride_in(stride_in),
        .depth_in(depth_in), .scale_in(scale_in), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .de(de), .vblank_irq(vblank_irq), .frame_count(frame_count)
    );

    initial pxl_clk = 1'b0;
    always #5 pxl_clk = ~pxl_clk;

    // BRAM model: data for an address appears LAT enabled cycles after it is presented
    logic          use_const;
    logic [31:0]   mem_const;
    logic [AW-1:0] apipe [LAT];

    function automatic logic [31:0] hash_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {17'd0, a};
        return (x * 32'h9E37_79B1) ^ (x << 7) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge pxl_clk) begin
        if (clk_en) begin
            apipe[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign mem_data = use_const ? mem_const : hash_word(apipe[LAT-1]);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [26:0] exp;
    } sb_t;
    sb_t sb[$];

    // Reference state
    int            mh, mv, ecnt, irq_cnt;
    logic [AW-1:0] m_base, m_stride, m_lb;
    logic [2:0]    m_depth;
    logic [1:0]    m_scale;
    logic [15:0]   m_frame;
    logic          m_irq;

    function automatic logic [23:0] ref_rgb(input logic [2:0] dep, input int idx, input logic [31:0] w);
        int f, r, g, b;
        case (dep)
            3'd1: begin
                f = int'((w >> (16 * idx)) & 32'hFFFF);
                r = (f >> 11) & 31; g = (f >> 5) & 63; b = f & 31;
                r = (r << 3) | (r >> 2); g = (g << 2) | (g >> 4); b = (b << 3) | (b >> 2);
            end
            3'd2: begin
                f = int'((w >> (8 * idx)) & 32'hFF);
                r = f >> 5; g = (f >> 2) & 7; b = (f & 3) * 8'h55;
                r = (r << 5) | (r << 2) | (r >> 1); g = (g << 5) | (g << 2) | (g >> 1);
            end
            3'd3: begin
                f = int'((w >> (4 * idx)) & 32'hF);
                r = f * 17; g = r; b = r;
            end
            3'd4: begin
                r = ((w >> idx) & 32'h1) != 0 ? 255 : 0; g = r; b = r;
            end
            default: begin
                r = int'((w >> 16) & 32'hFF); g = int'((w >> 8) & 32'hFF); b = int'(w & 32'hFF);
            end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic load_shadows();
        m_base = base_in; m_stride = stride_in; m_depth = depth_in; m_scale = scale_in;
        m_lb = base_in;
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; m_base = '0; m_stride = '0; m_depth = '0; m_scale = '0;
        m_lb = '0; m_frame = '0; m_irq = 1'b0;
        sb.delete();
    endtask

    // One pxl_clk period; entered and left 1 time unit after a rising edge
    task automatic cyc(input bit en);
        int            ppw, px, idx, nv;
        logic          act, hs, vs, hw, eofv;
        logic [AW-1:0] ea;
        logic [23:0]   rgb;
        sb_t           e;
        clk_en = en;
        @(negedge pxl_clk);
        if (en && enable) begin
            case (m_depth)
                3'd1: ppw = 2;
                3'd2: ppw = 4;
                3'd3: ppw = 8;
                3'd4: ppw = 32;
                default: ppw = 1;
            endcase
            act = (mh < int'(h_end_disp)) && (mv < int'(v_end_disp));
            hs  = (mh >= int'(h_srt_sync) && mh < int'(h_end_sync)) ? !hsync_pol : hsync_pol;
            vs  = (mv >= int'(v_srt_sync) && mv < int'(v_end_sync)) ? !vsync_pol : vsync_pol;
            px  = mh >> m_scale;
            idx = px % ppw;
            ea  = m_lb + AW'(px / ppw);
            check_eq("mem_en", {31'd0, mem_en}, {31'd0, act});
            if (act) check_eq("mem_addr", {17'd0, mem_addr}, {17'd0, ea});
            rgb = act ? ref_rgb(m_depth, idx, use_const ? mem_const : hash_word(ea)) : 24'd0;
            e.due = ecnt + LAT + 1;
            e.exp = {act, hs, vs, rgb};
            sb.push_back(e);
        end else begin
            check_eq("mem_en_idle", {31'd0, mem_en}, 32'd0);
        end
        @(posedge pxl_clk);
        #1;
        m_irq = 1'b0;
        if (en) begin
            ecnt++;
            if (!enable) begin
                mh = 0; mv = 0;
                load_shadows();
                check_eq("off_out", {5'd0, de, hsync, vsync, red, green, blue}, 32'd0);
            end else begin
                hw   = (mh == int'(h_total) - 1);
                eofv = hw && (mv == int'(v_total) - 1);
                nv   = hw ? (eofv ? 0 : mv + 1) : mv;
                m_irq = hw && (nv == int'(v_end_disp));
                if (eofv) begin
                    load_shadows();
                    m_frame++;
                end else if (hw && mv < int'(v_end_disp) &&
                             (mv % (1 << m_scale)) == ((1 << m_scale) - 1)) begin
                    m_lb = m_lb + m_stride;
                end
                mh = hw ? 0 : mh + 1;
                mv = nv;
            end
        end
        if (vblank_irq) irq_cnt++;
        check_eq("vblank_irq", {31'd0, vblank_irq}, {31'd0, m_irq});
        check_eq("frame_count", {16'd0, frame_count}, {16'd0, m_frame});
        while (sb.size() > 0 && sb[0].due <= ecnt) begin
            e = sb.pop_front();
            check_eq("pixel", {5'd0, de, hsync, vsync, red, green, blue}, {5'd0, e.exp});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    // Drop enable for two enabled cycles so new shadows load, then resume
    task automatic reconfig();
        enable = 1'b0;
        sb.delete();
        run(2);
        enable = 1'b1;
    endtask

    task automatic set_timing(input int ht, input int hd, input int hs0, input int hs1,
                              input int vt, input int vd, input int vs0, input int vs1);
        h_total = CW'(ht); h_end_disp = CW'(hd); h_srt_sync = CW'(hs0); h_end_sync = CW'(hs1);
        v_total = CW'(vt); v_end_disp = CW'(vd); v_srt_sync = CW'(vs0); v_end_sync = CW'(vs1);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; enable = 1'b0;
        hsync_pol = 1'b0; vsync_pol = 1'b0;
        base_in = 15'h10; stride_in = 15'd4; depth_in = 3'd0; scale_in = 2'd0;
        use_const = 1'b0; mem_const = '0;
        set_timing(10, 4, 6, 8, 6, 3, 4, 5);
        ecnt = 0; irq_cnt = 0;
        model_reset();
        #12;
        check_eq("rst_out", {5'd0, de, hsync, vsync, red, green, blue}, 32'd0);
        check_eq("rst_mem", {16'd0, mem_en, mem_addr}, 32'd0);
        check_eq("rst_irq_fc", {15'd0, vblank_irq, frame_count}, 32'd0);
        @(negedge pxl_clk);
        rst = 1'b0;
        @(posedge pxl_clk);
        #1;

        // Small timing, 32bpp, two full frames
        reconfig();
        irq_cnt = 0;
        run(130);
        check_eq("irq_per_frame", irq_cnt, 2);
        check_eq("frames_small", {16'd0, frame_count}, 32'd2);

        // RGB565 with stride across lines
        base_in = 15'h100; stride_in = 15'd8; depth_in = 3'd1;
        use_const = 1'b1; mem_const = 32'h11E3_18E1;
        reconfig();
        run(60);

        // Mono with 2x replication on a wider raster
        set_timing(24, 16, 18, 21, 8, 5, 6, 7);
        base_in = 15'h40; stride_in = 15'd3; depth_in = 3'd4; scale_in = 2'd1;
        mem_const = 32'h0000_0005;
        reconfig();
        run(200);

        // RGB332, then frame parameters changed mid-frame
        base_in = 15'h7FF0; stride_in = 15'd9; depth_in = 3'd2; scale_in = 2'd0;
        use_const = 1'b0;
        reconfig();
        run(50);
        base_in = 15'h300; stride_in = 15'd5; depth_in = 3'd3; scale_in = 2'd2;
        run(400);

        // Negative syncs, reserved depth, clk_en every other cycle
        hsync_pol = 1'b1; vsync_pol = 1'b1;
        base_in = 15'h1234; stride_in = 15'd11; depth_in = 3'd6; scale_in = 2'd0;
        reconfig();
        for (int i = 0; i < 420; i++) cyc(i[0] == 1'b0);

        // enable dropped mid-line
        hsync_pol = 1'b0; vsync_pol = 1'b0; depth_in = 3'd1; base_in = 15'h222;
        reconfig();
        run(29);
        enable = 1'b0;
        sb.delete();
        #1;
        check_eq("en_off_now", {4'd0, mem_en, de, hsync, vsync, red, green, blue}, 32'd0);
        #1;
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        enable = 1'b1;
        run(60);

        // Async reset mid-frame
        run(30);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out", {5'd0, de, hsync, vsync, red, green, blue}, 32'd0);
        check_eq("arst_mem", {31'd0, mem_en}, 32'd0);
        check_eq("arst_fc", {15'd0, vblank_irq, frame_count}, 32'd0);
        clk_en = 1'b0;
        model_reset();
        @(negedge pxl_clk);
        rst = 1'b0;
        @(posedge pxl_clk);
        #1;
        run(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
